// File: rtl/johnson_seq_ctrl_if.sv
// Control/status bundle for johnson_seq_ctrl.
// JSEQ_HOLD_EN adds the iHold input.
interface johnson_seq_ctrl_if #(
    parameter int WIDTH  = 4,
    parameter int DIV_W  = 16,
    parameter int STEP_W = 8
);
    logic              iStart;
    logic              iStop;
    logic              iDir;
    logic [STEP_W-1:0] iSteps;
    logic [DIV_W-1:0]  iDiv;
`ifdef JSEQ_HOLD_EN
    logic              iHold;
`endif
    logic [WIDTH-1:0]  oPhase;
    logic              oBusy;
    logic              oDone;
    logic              oStepTick;

    modport master (
        output iStart, iStop, iDir, iSteps, iDiv,
`ifdef JSEQ_HOLD_EN
        output iHold,
`endif
        input  oPhase, oBusy, oDone, oStepTick
    );

    modport slave (
        input  iStart, iStop, iDir, iSteps, iDiv,
`ifdef JSEQ_HOLD_EN
        input  iHold,
`endif
        output oPhase, oBusy, oDone, oStepTick
    );
endinterface

// File: rtl/johnson_seq_ctrl.sv
// Run-control sequencer for a Johnson phase counter.
// Optional JSEQ_HOLD_EN: iHold freezes the run without leaving it.
module johnson_seq_ctrl #(
    parameter int WIDTH  = 4,
    parameter int DIV_W  = 16,
    parameter int STEP_W = 8
) (
    input  logic iClk,
    input  logic iRst_n,
    johnson_seq_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  phase_q, phase_d;
    logic [DIV_W-1:0]  presc_q, presc_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [STEP_W-1:0] cnt_q, cnt_d;
    logic [STEP_W-1:0] steps_q, steps_d;
    logic              dir_q, dir_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              tick_q, tick_d;
    logic              hold;
    logic [WIDTH-1:0]  fwd_phase;
    logic [WIDTH-1:0]  rev_phase;

`ifdef JSEQ_HOLD_EN
    assign hold = bus.iHold;
`else
    assign hold = 1'b0;
`endif

    assign fwd_phase = {~phase_q[0], phase_q[WIDTH-1:1]};
    assign rev_phase = {phase_q[WIDTH-2:0], ~phase_q[WIDTH-1]};

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        presc_d = presc_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        steps_d = steps_q;
        dir_d   = dir_q;
        tick_d  = 1'b0;
        // Status flags trail the state by one edge
        busy_d  = (state_q == S_RUN);
        done_d  = (state_q == S_DONE);
        unique case (state_q)
            S_IDLE: begin
                if (bus.iStart && !bus.iStop) begin
                    dir_d   = bus.iDir;
                    steps_d = bus.iSteps;
                    div_d   = bus.iDiv;
                    presc_d = '0;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (bus.iStop) begin
                    state_d = S_IDLE;
                end else if (!hold) begin
                    if (presc_q == div_q) begin
                        presc_d = '0;
                        phase_d = dir_q ? rev_phase : fwd_phase;
                        tick_d  = 1'b1;
                        cnt_d   = cnt_q + 1'b1;
                        if (steps_q != '0 && cnt_d == steps_q) begin
                            state_d = S_DONE;
                        end
                    end else begin
                        presc_d = presc_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q <= S_IDLE;
            phase_q <= '0;
            presc_q <= '0;
            div_q   <= '0;
            cnt_q   <= '0;
            steps_q <= '0;
            dir_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            presc_q <= presc_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            steps_q <= steps_d;
            dir_q   <= dir_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            tick_q  <= tick_d;
        end
    end

    assign bus.oPhase    = phase_q;
    assign bus.oBusy     = busy_q;
    assign bus.oDone     = done_q;
    assign bus.oStepTick = tick_q;
endmodule

// File: tb/tb_johnson_seq_ctrl.sv
// Self-checking bench for johnson_seq_ctrl.
// Builds with or without JSEQ_HOLD_EN.
module tb_johnson_seq_ctrl;
    localparam int W = 4;

    logic iClk;
    logic iRst_n;
    int   total;
    int   bad;

    johnson_seq_ctrl_if #(.WIDTH(W), .DIV_W(16), .STEP_W(8)) bus ();

    johnson_seq_ctrl #(.WIDTH(W), .DIV_W(16), .STEP_W(8)) dut (
        .iClk   (iClk),
        .iRst_n (iRst_n),
        .bus    (bus.slave)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    // Reference: phase is an index k into the 2W-long ring
    bit m_run, m_fin, m_dir;
    int m_wait, m_left, m_div, m_k;
    bit e_busy, e_done, e_tick;

    function automatic logic [W-1:0] k2ph(input int k);
        logic [W-1:0] p;
        p = '0;
        for (int b = 0; b < W; b++) begin
            if (k <= W) p[b] = (b >= W - k);
            else        p[b] = (b < 2 * W - k);
        end
        return p;
    endfunction

    function automatic void model_reset();
        m_run = 0; m_fin = 0; m_dir = 0;
        m_wait = 0; m_left = 0; m_div = 0; m_k = 0;
        e_busy = 0; e_done = 0; e_tick = 0;
    endfunction

    function automatic void model_edge();
        bit h;
`ifdef JSEQ_HOLD_EN
        h = bus.iHold;
`else
        h = 1'b0;
`endif
        e_busy = m_run;
        e_done = m_fin;
        e_tick = 0;
        if (m_fin) begin
            m_fin = 0;
        end else if (m_run) begin
            if (bus.iStop) begin
                m_run = 0;
            end else if (!h) begin
                if (m_wait == 0) begin
                    m_k = m_dir ? (m_k + 2 * W - 1) % (2 * W)
                                : (m_k + 1) % (2 * W);
                    e_tick = 1;
                    m_wait = m_div;
                    if (m_left > 0) begin
                        m_left--;
                        if (m_left == 0) begin
                            m_run = 0;
                            m_fin = 1;
                        end
                    end
                end else begin
                    m_wait--;
                end
            end
        end else if (bus.iStart && !bus.iStop) begin
            m_run  = 1;
            m_dir  = bus.iDir;
            m_div  = int'(bus.iDiv);
            m_wait = m_div;
            m_left = int'(bus.iSteps);
        end
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic cyc(input bit cmp);
        @(posedge iClk);
        model_edge();
        #1;
        if (cmp) begin
            chk("model_phase", bus.oPhase, k2ph(m_k));
            chk("model_busy", bus.oBusy, e_busy);
            chk("model_done", bus.oDone, e_done);
            chk("model_tick", bus.oStepTick, e_tick);
        end
    endtask

    task automatic drive(input bit st, input bit sp, input bit dir,
                         input int steps, input int div);
        bus.iStart = st;
        bus.iStop  = sp;
        bus.iDir   = dir;
        bus.iSteps = 8'(steps);
        bus.iDiv   = 16'(div);
    endtask

    task automatic do_reset();
        @(negedge iClk);
        iRst_n = 1'b0;
        model_reset();
        @(negedge iClk);
        iRst_n = 1'b1;
    endtask

    typedef struct {
        bit           st, sp, dir;
        int           steps, div;
        logic [W-1:0] ph;
        bit           busy, done, tick;
    } vec_t;

    vec_t tv[11];
    logic [W-1:0] held;
    bit saw_done;

    initial begin
        total = 0;
        bad   = 0;
        iRst_n = 1'b0;
        drive(0, 0, 0, 0, 0);
`ifdef JSEQ_HOLD_EN
        bus.iHold = 1'b0;
`endif
        model_reset();
        #12;
        chk("reset_phase", bus.oPhase, 4'b0000);
        chk("reset_busy", bus.oBusy, 1'b0);
        chk("reset_done", bus.oDone, 1'b0);
        chk("reset_tick", bus.oStepTick, 1'b0);
        @(negedge iClk);
        iRst_n = 1'b1;

        // div=1 burst of 3; mid-run input changes must be ignored
        tv[0]  = '{1, 0, 0, 3, 1, 4'b0000, 0, 0, 0};
        tv[1]  = '{0, 0, 0, 3, 1, 4'b0000, 1, 0, 0};
        tv[2]  = '{0, 0, 0, 3, 1, 4'b1000, 1, 0, 1};
        tv[3]  = '{1, 0, 1, 0, 5, 4'b1000, 1, 0, 0};
        tv[4]  = '{0, 0, 1, 0, 5, 4'b1100, 1, 0, 1};
        tv[5]  = '{0, 0, 0, 3, 1, 4'b1100, 1, 0, 0};
        tv[6]  = '{0, 0, 0, 3, 1, 4'b1110, 1, 0, 1};
        tv[7]  = '{1, 0, 0, 3, 1, 4'b1110, 0, 1, 0};
        tv[8]  = '{0, 0, 0, 3, 1, 4'b1110, 0, 0, 0};
        tv[9]  = '{1, 1, 0, 3, 1, 4'b1110, 0, 0, 0};
        tv[10] = '{0, 0, 0, 3, 1, 4'b1110, 0, 0, 0};
        for (int i = 0; i < 11; i++) begin
            drive(tv[i].st, tv[i].sp, tv[i].dir, tv[i].steps, tv[i].div);
            cyc(0);
            chk($sformatf("tv%0d_phase", i), bus.oPhase, tv[i].ph);
            chk($sformatf("tv%0d_busy", i), bus.oBusy, tv[i].busy);
            chk($sformatf("tv%0d_done", i), bus.oDone, tv[i].done);
            chk($sformatf("tv%0d_tick", i), bus.oStepTick, tv[i].tick);
        end

        // Asynchronous reset in the middle of a run
        drive(1, 0, 0, 0, 3);
        cyc(1);
        drive(0, 0, 0, 0, 3);
        cyc(1);
        cyc(1);
        #3;
        iRst_n = 1'b0;
        model_reset();
        #1;
        chk("arst_phase", bus.oPhase, 4'b0000);
        chk("arst_busy", bus.oBusy, 1'b0);
        chk("arst_done", bus.oDone, 1'b0);
        @(negedge iClk);
        @(negedge iClk);
        iRst_n = 1'b1;
        cyc(1);
        cyc(1);
        chk("arst_idle", bus.oBusy, 1'b0);

        // Reverse burst of 2 from 0000
        drive(1, 0, 1, 2, 0);
        cyc(1);
        drive(0, 0, 1, 2, 0);
        cyc(1);
        chk("rev_step1", bus.oPhase, 4'b0001);
        cyc(1);
        chk("rev_step2", bus.oPhase, 4'b0011);
        cyc(1);
        chk("rev_done", bus.oDone, 1'b1);
        cyc(1);

        // Continuous div=0 for 17 steps, then stop
        do_reset();
        drive(1, 0, 0, 0, 0);
        cyc(1);
        drive(0, 0, 0, 0, 0);
        saw_done = 0;
        for (int i = 0; i < 17; i++) begin
            cyc(1);
            if (bus.oDone) saw_done = 1;
        end
        chk("cont_phase", bus.oPhase, 4'b1000);
        chk("cont_nodone", saw_done, 1'b0);
        drive(0, 1, 0, 0, 0);
        cyc(1);
        drive(0, 0, 0, 0, 0);
        held = bus.oPhase;
        cyc(1);
        cyc(1);
        chk("stop_hold", bus.oPhase, held);
        chk("stop_busy", bus.oBusy, 1'b0);

        // Stop on the prescaler terminal-count edge
        drive(1, 0, 0, 0, 3);
        cyc(1);
        drive(0, 0, 0, 0, 3);
        cyc(1);
        cyc(1);
        cyc(1);
        held = bus.oPhase;
        drive(0, 1, 0, 0, 3);
        cyc(1);
        drive(0, 0, 0, 0, 3);
        chk("tc_stop_phase", bus.oPhase, held);
        chk("tc_stop_tick", bus.oStepTick, 1'b0);
        cyc(1);
        chk("tc_stop_busy", bus.oBusy, 1'b0);
        chk("tc_stop_done", bus.oDone, 1'b0);

`ifdef JSEQ_HOLD_EN
        do_reset();
        drive(1, 0, 0, 2, 1);
        cyc(1);
        drive(0, 0, 0, 2, 1);
        cyc(1);
        cyc(1);
        chk("hold_step1", bus.oPhase, 4'b1000);
        bus.iHold = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            chk("hold_busy", bus.oBusy, 1'b1);
            chk("hold_phase", bus.oPhase, 4'b1000);
        end
        bus.iHold = 1'b0;
        cyc(1);
        chk("hold_nostep", bus.oPhase, 4'b1000);
        cyc(1);
        chk("hold_step2", bus.oPhase, 4'b1100);
        cyc(1);
        chk("hold_done", bus.oDone, 1'b1);
`endif

        // Random traffic against the reference model
        for (int i = 0; i < 800; i++) begin
            drive($urandom_range(0, 7) == 0, $urandom_range(0, 23) == 0,
                  1'($urandom_range(0, 1)), $urandom_range(0, 6),
                  $urandom_range(0, 3));
`ifdef JSEQ_HOLD_EN
            bus.iHold = ($urandom_range(0, 4) == 0);
`endif
            cyc(1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/johnson_seq_ctrl.md
Name: johnson_seq_ctrl

Overview:
Run-control sequencer for a WIDTH-bit Johnson phase counter (2*WIDTH states, e.g. 0000→1000→1100→1110→1111→0111→0011→0001→0000).
- Adds start/stop control, a programmable step-rate prescaler, forward/reverse direction and a finite step-count burst mode.
- Sits between the control logic (button, register or FSM) and the phase-driven load (LED bar, stepper phases).
- Drives the phase bus directly, together with busy, done and step-tick status.

Parameters:
WIDTH, 4, Johnson register width; sequence length 2*WIDTH.
DIV_W, 16, prescaler divide-value width.
STEP_W, 8, burst step-count width.

Ports:
iClk  in  1  clock, rising edge.
iRst_n  in  1  asynchronous active-low reset.
iStart  in  1  one-cycle start request.
iStop  in  1  one-cycle stop request.
iDir  in  1  0 = forward (shift right, inject ~LSB at MSB); 1 = reverse.
iSteps  in  STEP_W  number of steps per burst; 0 = run continuously.
iDiv  in  DIV_W  step period minus 1, in clocks.
oPhase  out  WIDTH  registered Johnson phase.
oBusy  out  1  high while in RUN.
oDone  out  1  one-cycle pulse at burst completion.
oStepTick  out  1  one-cycle pulse in the cycle oPhase takes a new value.

Behaviour:
- Reset (async, iRst_n=0): state=IDLE, oPhase=0, prescaler=0, step counter=0, oBusy=0, oDone=0, oStepTick=0. All outputs are registered.
- States: IDLE, RUN, DONE.
- IDLE:
  - Holds oPhase.
  - iStart=1 and iStop=0 at an edge → latch iDir, iSteps, iDiv; clear prescaler; go to RUN.
  - iStart with iStop in the same cycle → stay IDLE (stop has priority).
- RUN:
  - oBusy=1. Prescaler counts 0..DIV.
  - At the edge where prescaler==DIV: prescaler→0, oPhase advances one Johnson step in the latched direction, oStepTick=1 for the following cycle.
  - First step occurs DIV+1 edges after the start edge. DIV=0 steps every clock.
  - Forward next = {~q[0], q[WIDTH-1:1]}. Reverse next = {q[WIDTH-2:0], ~q[WIDTH-1]}.
  - Wrap-around is implicit: 0001→0000 forward, 0000→0001 reverse.
  - Burst (latched steps N>0): on the Nth step edge go to DONE. Continuous (N=0): never self-terminates.
  - iStop → IDLE at that edge, no step even if the prescaler terminal count coincides, no oDone, oPhase held.
  - iStart is ignored. Input changes to iDir/iSteps/iDiv have no effect until the next start.
- DONE: oDone=1, oBusy=0 for exactly one cycle, then IDLE unconditionally. iStart during DONE is ignored.
- oPhase is never cleared except by reset. A new start resumes from the current phase.
- Reset mid-RUN: immediate return to reset values; no oDone.
- Non-Johnson oPhase values are unreachable.

Optional Feature:
JSEQ_HOLD_EN
- Defined: adds input iHold (1 bit). While iHold=1 in RUN, the prescaler and step counter freeze, no steps occur, oBusy stays 1, and iStop still has effect. Counting resumes from the frozen value when iHold drops.
- Undefined: port absent; behaviour as above.

Test Plan:
- Reset asserted mid-operation with phase 1110 → oPhase=0000, oBusy=0, oDone=0 immediately (asynchronous); stays IDLE after release.
- iDiv=1, iSteps=3, iDir=0, start pulse at edge 0 → oPhase=1000@2, 1100@4, 1110@6, oStepTick high one cycle after each; oDone high one cycle at 7; oBusy low from 7.
- iDiv=0, iSteps=0, iDir=0, run 17 clocks → oPhase cycles all 8 states twice and returns to 1000; oDone never asserts; iStop then freezes the phase.
- From phase 0000, iDir=1, iDiv=0, iSteps=2 → oPhase 0001 then 0011; oDone pulse.
- iDiv=3, continuous; iStop on the prescaler terminal-count edge → no step, IDLE, no oDone. iStart+iStop together in IDLE → stays IDLE.
- (JSEQ_HOLD_EN) iDiv=1, iSteps=2; iHold=1 for 5 clocks after the first step → second step delayed by exactly 5 clocks; oBusy stays 1 throughout.
